cdc_req_initiator: RTL
======================

# cdc_req_initiator

Single-clock request/response initiator in the source clock domain. It takes one command at a time from a local master, tags it, and pushes it into the source port of a four-phase CDC handshake channel. It then waits for the tagged response on the return channel's destination port, enforcing a timeout. Stale or mismatched responses are discarded, and the block returns exactly one result per command to the master.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- CmdWidth, 32: command payload width.
- RspWidth, 32: response payload width.
- TagWidth, 4: request tag width. Tags wrap modulo 2^TagWidth.
- Timeout, 256: response wait limit in cycles. Must be ≥2.

Ports:
- src_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- cmd_valid_i  in  1  master command valid.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_data_i  in  CmdWidth  command payload.
- res_valid_o  out  1  result valid, held until accepted.
- res_ready_i  in  1  master result ready.
- res_data_o  out  RspWidth  response payload; 0 on timeout.
- res_status_o  out  2  2'b00 OK, 2'b01 TIMEOUT.
- hs_valid_o  out  1  request valid to the handshake source port.
- hs_data_o  out  TagWidth+CmdWidth  {tag, cmd}.
- hs_ready_i  in  1  single-cycle completion pulse from the handshake source port.
- rsp_valid_i  in  1  response valid from the return-channel destination port.
- rsp_data_i  in  TagWidth+RspWidth  {tag, rsp}.
- rsp_ready_o  out  1  response ready.
- busy_o  out  1  high in every state except IDLE.
- drop_cnt_o  out  8  count of discarded responses, saturating.

## Operation
FSM states are IDLE, REQ, GAP, WAIT, DONE. All outputs are registered or decoded from the state register.

Per-state outputs:
- IDLE: cmd_ready_o=1.
  - cmd_valid_i -> REQ.
  - On that transition: cur_tag<=next_tag, next_tag<=next_tag+1, hs_data_o<={next_tag, cmd_data_i}.
- REQ: hs_valid_o=1, hs_data_o held stable.
  - hs_ready_i -> GAP.
  - No timeout in REQ; the state is exited only by hs_ready_i.
- GAP: hs_valid_o=0 for exactly one cycle. This is the mandatory valid de-assert required by the handshake source lock. Next state is WAIT unless a matching response arrives.
- WAIT: waits for the matching response.
- DONE: res_valid_o=1; res_data_o and res_status_o held stable.
  - res_ready_i -> IDLE.
- rsp_ready_o = (state != DONE).

Response handling:
- A match is rsp_valid_i && rsp_ready_o && state∈{GAP, WAIT} && rsp tag==cur_tag.
  - Action: capture rsp payload, status OK, -> DONE.
- Any other accepted response is a drop: state IDLE/REQ, or a tag mismatch.
  - Action: discard it; drop_cnt_o+1, saturating at 255.

Timeout counter:
- Width $clog2(Timeout+1). Cleared on entry to GAP.
- Increments on every GAP/WAIT cycle that has no match.
- If the counter == Timeout-1 and there is no match that cycle: -> DONE with status TIMEOUT and res_data_o=0.

hs_ready_i is ignored outside REQ.

## Timing
Reset values:
- State IDLE. cmd_ready_o=1, rsp_ready_o=1, busy_o=0.
- hs_valid_o=0, hs_data_o=0.
- res_valid_o=0, res_data_o=0, res_status_o=0.
- drop_cnt_o=0, cur_tag=0, next_tag=0.

Cycle-level behaviour:
- Command accepted at cycle 0 -> hs_valid_o=1 from cycle 1. The first command after reset carries tag 0.
- hs_ready_i at cycle k -> hs_valid_o=0 at k+1 (GAP) -> WAIT at k+2.
- Match at cycle m -> res_valid_o=1 at m+1.
- No response -> DONE exactly Timeout cycles after GAP entry.
- A match in the same cycle the counter reaches Timeout-1 -> the match wins, status OK.
- res_valid_o && res_ready_i at cycle n -> IDLE at n+1; cmd_ready_o=1 at n+1. At most one command is in flight.
- In DONE rsp_ready_o=0, so responses back-pressure and are neither dropped nor counted.
- Tag wrap: next_tag 2^TagWidth-1 -> 0.
- A late response from a timed-out command has the old tag and is dropped.
- Reset mid-operation: immediate return to reset values. The far handshake channel must be reset together with this block.

## Test plan
- Basic flow. Stimulus: cmd 0x12345678; hs_ready_i pulse 3 cycles after hs_valid_o rises; response {tag 0, 0xCAFEF00D} 5 cycles later. Required: hs_data_o={4'h0, 0x12345678}; hs_valid_o low for exactly one cycle; res_data_o=0xCAFEF00D; status 00; drop_cnt_o=0.
- Timeout. Stimulus: Timeout=8, no response. Required: DONE 8 cycles after GAP entry; status 01; res_data_o=0. Then a late response with tag 0 arrives during the next command (tag 1). Required: it is dropped, drop_cnt_o=1, and the tag-1 response completes normally.
- Tag wrap and mismatch. Stimulus: 17 commands; in the 17th, inject a tag-1 response before the tag-0 one. Required: the 17th command uses tag 0; the tag-1 response is dropped; the tag-0 response returns OK.
- Back-pressure. Stimulus: hold res_ready_i=0 for 20 cycles while rsp_valid_i stays high. Required: rsp_ready_o=0, result outputs stable, no drop counted; IDLE one cycle after res_ready_i.
- Boundary race. Stimulus: Timeout=4, matching response exactly in the 4th wait cycle. Required: status OK. Then 300 unsolicited responses in IDLE. Required: drop_cnt_o saturates at 255.
- Async reset asserted in WAIT. Required: all outputs return to reset values immediately; the next command carries tag 0.

Source files
------------

// File: rtl/cdc_req_initiator.sv
`default_nettype none
// ============================================================================
// Module   : cdc_req_initiator
// Brief    : Source-domain request/response initiator. Tags one command at a
//            time, pushes it into a four-phase CDC handshake source port,
//            waits for the tagged response with a timeout, drops stale or
//            mismatched responses and returns one result per command.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_req_initiator #(
  parameter int CmdWidth = 32,
  parameter int RspWidth = 32,
  parameter int TagWidth = 4,
  parameter int Timeout  = 256
) (
  input  logic                         src_clk,
  input  logic                         reset,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [CmdWidth-1:0]          cmd_data_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [RspWidth-1:0]          res_data_o,
  output logic [1:0]                   res_status_o,
  output logic                         hs_valid_o,
  output logic [TagWidth+CmdWidth-1:0] hs_data_o,
  input  logic                         hs_ready_i,
  input  logic                         rsp_valid_i,
  input  logic [TagWidth+RspWidth-1:0] rsp_data_i,
  output logic                         rsp_ready_o,
  output logic                         busy_o,
  output logic [7:0]                   drop_cnt_o
);

  localparam int                 c_CNT_W    = $clog2(Timeout + 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(Timeout - 1);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_REQ  = 3'd1;
  localparam logic [2:0] c_ST_GAP  = 3'd2;
  localparam logic [2:0] c_ST_WAIT = 3'd3;
  localparam logic [2:0] c_ST_DONE = 3'd4;

  localparam logic [1:0] c_STAT_OK      = 2'b00;
  localparam logic [1:0] c_STAT_TIMEOUT = 2'b01;

  logic [2:0]                   r_state;
  logic [2:0]                   w_state_nxt;
  logic [TagWidth-1:0]          r_cur_tag;
  logic [TagWidth-1:0]          r_next_tag;
  logic [TagWidth+CmdWidth-1:0] r_hs_data;
  logic [RspWidth-1:0]          r_res_data;
  logic [1:0]                   r_res_status;
  logic [7:0]                   r_drop_cnt;
  logic [c_CNT_W-1:0]           r_tmo_cnt;

  logic                w_cmd_ready;
  logic                w_hs_valid;
  logic                w_res_valid;
  logic                w_rsp_ready;
  logic                w_busy;
  logic                w_cmd_acc;
  logic                w_gap_entry;
  logic                w_in_wait;
  logic                w_rsp_acc;
  logic                w_match;
  logic                w_drop;
  logic                w_tmo;
  logic [TagWidth-1:0] w_rsp_tag;
  logic [RspWidth-1:0] w_rsp_payload;

  assign w_rsp_tag     = rsp_data_i[TagWidth+RspWidth-1:RspWidth];
  assign w_rsp_payload = rsp_data_i[RspWidth-1:0];

  assign w_cmd_acc   = (r_state == c_ST_IDLE) && cmd_valid_i;
  assign w_gap_entry = (r_state == c_ST_REQ) && hs_ready_i;
  assign w_in_wait   = (r_state == c_ST_GAP) || (r_state == c_ST_WAIT);
  assign w_rsp_acc   = rsp_valid_i && w_rsp_ready;
  assign w_match     = w_rsp_acc && w_in_wait && (w_rsp_tag == r_cur_tag);
  assign w_drop      = w_rsp_acc && !w_match;
  // A response arriving on the last wait cycle beats the timeout.
  assign w_tmo       = w_in_wait && (r_tmo_cnt == c_TMO_LAST) && !w_match;

  // State register.
  always_ff @(posedge src_clk or negedge reset) begin
    if (!reset) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; hs_ready_i only matters while requesting.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (cmd_valid_i) w_state_nxt = c_ST_REQ;
      c_ST_REQ:  if (hs_ready_i)  w_state_nxt = c_ST_GAP;
      c_ST_GAP,
      c_ST_WAIT: w_state_nxt = (w_match || w_tmo) ? c_ST_DONE : c_ST_WAIT;
      c_ST_DONE: if (res_ready_i) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output decode from the state register; GAP keeps hs_valid low one cycle.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_hs_valid  = 1'b0;
    w_res_valid = 1'b0;
    w_rsp_ready = 1'b1;
    w_busy      = 1'b1;
    case (r_state)
      c_ST_IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
      end
      c_ST_REQ:  w_hs_valid = 1'b1;
      c_ST_DONE: begin
        w_res_valid = 1'b1;
        w_rsp_ready = 1'b0;
      end
      default: ;
    endcase
  end

  // Tag allocation and request payload capture on command acceptance.
  always_ff @(posedge src_clk or negedge reset) begin
    if (!reset) begin
      r_cur_tag  <= '0;
      r_next_tag <= '0;
      r_hs_data  <= '0;
    end else if (w_cmd_acc) begin
      r_cur_tag  <= r_next_tag;
      r_next_tag <= r_next_tag + 1'b1;
      r_hs_data  <= {r_next_tag, cmd_data_i};
    end
  end

  // Response wait timer, restarted when the request handshake completes.
  always_ff @(posedge src_clk or negedge reset) begin
    if (!reset)                      r_tmo_cnt <= '0;
    else if (w_gap_entry)            r_tmo_cnt <= '0;
    else if (w_in_wait && !w_match)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Result capture: payload on match, zero with TIMEOUT status on expiry.
  always_ff @(posedge src_clk or negedge reset) begin
    if (!reset) begin
      r_res_data   <= '0;
      r_res_status <= c_STAT_OK;
    end else if (w_match) begin
      r_res_data   <= w_rsp_payload;
      r_res_status <= c_STAT_OK;
    end else if (w_tmo) begin
      r_res_data   <= '0;
      r_res_status <= c_STAT_TIMEOUT;
    end
  end

  // Saturating count of accepted responses that were discarded.
  always_ff @(posedge src_clk or negedge reset) begin
    if (!reset)                           r_drop_cnt <= 8'd0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign cmd_ready_o  = w_cmd_ready;
  assign hs_valid_o   = w_hs_valid;
  assign hs_data_o    = r_hs_data;
  assign res_valid_o  = w_res_valid;
  assign res_data_o   = r_res_data;
  assign res_status_o = r_res_status;
  assign rsp_ready_o  = w_rsp_ready;
  assign busy_o       = w_busy;
  assign drop_cnt_o   = r_drop_cnt;

endmodule
`default_nettype wire
